// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
// Shared definitions for the pipeline hazard controller: the controller state
// encoding, the x0 register constant and the load-use detection function.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // Hard-wired zero register; a load targeting it never creates a hazard.
    localparam logic [4:0] REG_X0 = 5'd0;

    // True when the ID instruction reads a register the EX load is about to write.
    function automatic logic is_load_use(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic       use_rs1,
        input logic [4:0] rs2,
        input logic       use_rs2
    );
        return mem_read && (rd != REG_X0) &&
               ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
// Bundle between the 5-stage datapath and the hazard controller.
//   Hazard inputs : id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd,
//                   ex_mem_read, ex_redirect, mem_periph
//   Control outs  : pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
//                   if_id_flush, id_ex_flush, ex_mem_flush, pc_sel
//   Perf counters : stall_cnt, flush_cnt
// master = datapath side, slave = hazard controller.
interface hazard_ctrl_if #(
    parameter int CNT_WIDTH = 16
);
    logic [4:0]           id_rs1;
    logic [4:0]           id_rs2;
    logic                 id_use_rs1;
    logic                 id_use_rs2;
    logic [4:0]           ex_rd;
    logic                 ex_mem_read;
    logic                 ex_redirect;
    logic                 mem_periph;

    logic                 pc_en;
    logic                 if_id_en;
    logic                 id_ex_en;
    logic                 ex_mem_en;
    logic                 mem_wb_en;
    logic                 if_id_flush;
    logic                 id_ex_flush;
    logic                 ex_mem_flush;
    logic                 pc_sel;
    logic [CNT_WIDTH-1:0] stall_cnt;
    logic [CNT_WIDTH-1:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd,
               ex_mem_read, ex_redirect, mem_periph,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, pc_sel,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd,
               ex_mem_read, ex_redirect, mem_periph,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, pc_sel,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// hazard_ctrl_sat_counter
// Event counter that sticks at all-ones instead of wrapping.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low clear
//   inc   : count one event this cycle
//   count : current value
module hazard_ctrl_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline control for the 5-stage RV32I datapath. Produces PC / pipeline
// register enables and flushes for load-use stalls, EX redirects and
// multi-cycle peripheral accesses in MEM, plus saturating perf counters.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   hz    : hazard_ctrl_if slave (hazard inputs, control outputs, counters)
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);

    // The access cycle in RUN is the first stall, so the counter covers the rest.
    localparam logic [3:0] WAIT_LOAD   = 4'(WAIT_CYCLES - 1);
    localparam state_t     PERIPH_NEXT = (WAIT_CYCLES == 1) ? ST_RELEASE : ST_WAIT;

    state_t               state;
    state_t               state_nxt;
    logic [3:0]           wait_cnt;
    logic [3:0]           wait_cnt_nxt;

    logic                 load_use;
    logic                 redirect_fire;
    logic                 stall_inc;

    logic                 pc_en;
    logic                 if_id_en;
    logic                 id_ex_en;
    logic                 ex_mem_en;
    logic                 mem_wb_en;
    logic                 if_id_flush;
    logic                 id_ex_flush;
    logic                 ex_mem_flush;
    logic                 pc_sel;
    logic [CNT_WIDTH-1:0] stall_cnt;
    logic [CNT_WIDTH-1:0] flush_cnt;

    assign load_use = is_load_use(hz.ex_mem_read, hz.ex_rd,
                                  hz.id_rs1, hz.id_use_rs1,
                                  hz.id_rs2, hz.id_use_rs2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_INIT;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        redirect_fire = 1'b0;
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_flush  = 1'b0;
        pc_sel        = 1'b0;

        case (state)
            ST_INIT: begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_en    = 1'b0;
                mem_wb_en    = 1'b0;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                state_nxt    = ST_RUN;
            end

            ST_WAIT: begin
                // Front of the pipe frozen; MEM keeps presenting to WB while the
                // datapath squashes the write. Redirect/load-use stay frozen too.
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_en  = 1'b0;
                ex_mem_en = 1'b0;
                wait_cnt_nxt = wait_cnt - 4'd1;
                if (wait_cnt == 4'd1) begin
                    state_nxt = ST_RELEASE;
                end
            end

            ST_RUN, ST_RELEASE: begin
                // In RELEASE mem_periph is the finishing access, not a new one.
                if ((state == ST_RUN) && hz.mem_periph) begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_en     = 1'b0;
                    ex_mem_en    = 1'b0;
                    wait_cnt_nxt = WAIT_LOAD;
                    state_nxt    = PERIPH_NEXT;
                end else begin
                    if (hz.ex_redirect) begin
                        pc_sel        = 1'b1;
                        if_id_flush   = 1'b1;
                        id_ex_flush   = 1'b1;
                        redirect_fire = 1'b1;
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                    state_nxt = ST_RUN;
                end
            end

            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    // INIT holds the PC too, but that is start-up, not a pipeline stall.
    assign stall_inc = !pc_en && (state != ST_INIT);

    hazard_ctrl_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    hazard_ctrl_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (redirect_fire),
        .count (flush_cnt)
    );

    assign hz.pc_en        = pc_en;
    assign hz.if_id_en     = if_id_en;
    assign hz.id_ex_en     = id_ex_en;
    assign hz.ex_mem_en    = ex_mem_en;
    assign hz.mem_wb_en    = mem_wb_en;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_flush  = id_ex_flush;
    assign hz.ex_mem_flush = ex_mem_flush;
    assign hz.pc_sel       = pc_sel;
    assign hz.stall_cnt    = stall_cnt;
    assign hz.flush_cnt    = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
// Directed bench for hazard_ctrl: one instance with WAIT_CYCLES=3 carries
// most of the sequence, a second with WAIT_CYCLES=1 covers the short access.
module tb_hazard_ctrl;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    hazard_ctrl_if #(.CNT_WIDTH(16)) hz  ();
    hazard_ctrl_if #(.CNT_WIDTH(16)) hz1 ();

    hazard_ctrl #(
        .WAIT_CYCLES (3),
        .CNT_WIDTH   (16)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz.slave)
    );

    hazard_ctrl #(
        .WAIT_CYCLES (1),
        .CNT_WIDTH   (16)
    ) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .hz    (hz1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        hz.id_rs1      = 5'd0;
        hz.id_rs2      = 5'd0;
        hz.id_use_rs1  = 1'b0;
        hz.id_use_rs2  = 1'b0;
        hz.ex_rd       = 5'd0;
        hz.ex_mem_read = 1'b0;
        hz.ex_redirect = 1'b0;
        hz.mem_periph  = 1'b0;
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        idle();
        hz1.id_rs1      = 5'd0;
        hz1.id_rs2      = 5'd0;
        hz1.id_use_rs1  = 1'b0;
        hz1.id_use_rs2  = 1'b0;
        hz1.ex_rd       = 5'd0;
        hz1.ex_mem_read = 1'b0;
        hz1.ex_redirect = 1'b0;
        hz1.mem_periph  = 1'b0;

        // Reset held
        #3;
        chk("rst_pc_en",     32'(hz.pc_en),        0);
        chk("rst_mem_wb_en", 32'(hz.mem_wb_en),    0);
        chk("rst_if_flush",  32'(hz.if_id_flush),  1);
        chk("rst_ex_flush",  32'(hz.ex_mem_flush), 1);
        chk("rst_stall_cnt", 32'(hz.stall_cnt),    0);

        // Release between edges: the cycle up to the next posedge is INIT
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("init_pc_en",    32'(hz.pc_en),        0);
        chk("init_if_flush", 32'(hz.if_id_flush),  1);
        chk("init_id_flush", 32'(hz.id_ex_flush),  1);
        chk("init_ex_flush", 32'(hz.ex_mem_flush), 1);
        chk("init_pc_sel",   32'(hz.pc_sel),       0);

        // First RUN cycle
        cyc();
        @(negedge clk);
        chk("run_pc_en",     32'(hz.pc_en),       1);
        chk("run_if_id_en",  32'(hz.if_id_en),    1);
        chk("run_mem_wb_en", 32'(hz.mem_wb_en),   1);
        chk("run_id_flush",  32'(hz.id_ex_flush), 0);
        chk("run_stall_cnt", 32'(hz.stall_cnt),   0);

        // Load-use through rs2
        cyc();
        hz.ex_mem_read = 1'b1;
        hz.ex_rd       = 5'd5;
        hz.id_rs1      = 5'd3;
        hz.id_use_rs1  = 1'b1;
        hz.id_rs2      = 5'd5;
        hz.id_use_rs2  = 1'b1;
        @(negedge clk);
        chk("lu_pc_en",     32'(hz.pc_en),       0);
        chk("lu_if_id_en",  32'(hz.if_id_en),    0);
        chk("lu_id_flush",  32'(hz.id_ex_flush), 1);
        chk("lu_ex_mem_en", 32'(hz.ex_mem_en),   1);
        chk("lu_mem_wb_en", 32'(hz.mem_wb_en),   1);
        cyc();
        idle();
        @(negedge clk);
        chk("lu_after_pc_en", 32'(hz.pc_en),       1);
        chk("lu_after_flush", 32'(hz.id_ex_flush), 0);
        chk("lu_stall_cnt",   32'(hz.stall_cnt),   1);

        // Load to x0 with matching rs1: no hazard
        cyc();
        hz.ex_mem_read = 1'b1;
        hz.ex_rd       = 5'd0;
        hz.id_rs1      = 5'd0;
        hz.id_use_rs1  = 1'b1;
        @(negedge clk);
        chk("x0_pc_en",    32'(hz.pc_en),       1);
        chk("x0_id_flush", 32'(hz.id_ex_flush), 0);

        // Matching rs2 that the instruction does not read: no hazard
        cyc();
        hz.ex_rd      = 5'd7;
        hz.id_rs1     = 5'd3;
        hz.id_rs2     = 5'd7;
        hz.id_use_rs2 = 1'b0;
        @(negedge clk);
        chk("nouse_pc_en", 32'(hz.pc_en), 1);
        cyc();
        idle();
        @(negedge clk);
        chk("nouse_stall_cnt", 32'(hz.stall_cnt), 1);

        // Peripheral access: u_dut (3 stall cycles), u_dut1 (1 stall cycle)
        cyc();
        hz.mem_periph  = 1'b1;
        hz1.mem_periph = 1'b1;
        @(negedge clk);
        chk("p0_pc_en",     32'(hz.pc_en),        0);
        chk("p0_id_ex_en",  32'(hz.id_ex_en),     0);
        chk("p0_ex_mem_en", 32'(hz.ex_mem_en),    0);
        chk("p0_mem_wb_en", 32'(hz.mem_wb_en),    1);
        chk("p0_ex_flush",  32'(hz.ex_mem_flush), 0);
        chk("w1_p0_pc_en",  32'(hz1.pc_en),       0);
        cyc();
        @(negedge clk);
        chk("p1_pc_en",       32'(hz.pc_en),     0);
        chk("w1_rel_pc_en",   32'(hz1.pc_en),    1);
        chk("w1_rel_if_id",   32'(hz1.if_id_en), 1);
        cyc();
        hz1.mem_periph = 1'b0;
        @(negedge clk);
        chk("p2_pc_en",       32'(hz.pc_en),      0);
        chk("w1_stall_cnt",   32'(hz1.stall_cnt), 1);
        chk("w1_run_pc_en",   32'(hz1.pc_en),     1);
        cyc();
        @(negedge clk);
        chk("p3_rel_pc_en",     32'(hz.pc_en),     1);
        chk("p3_rel_ex_mem_en", 32'(hz.ex_mem_en), 1);
        chk("p3_stall_cnt",     32'(hz.stall_cnt), 4);
        cyc();
        idle();
        @(negedge clk);
        chk("p4_pc_en",     32'(hz.pc_en),     1);
        chk("p4_stall_cnt", 32'(hz.stall_cnt), 4);

        // Redirect arriving with the access and held through WAIT
        cyc();
        hz.mem_periph  = 1'b1;
        hz.ex_redirect = 1'b1;
        @(negedge clk);
        chk("rw0_pc_sel",   32'(hz.pc_sel),      0);
        chk("rw0_if_flush", 32'(hz.if_id_flush), 0);
        chk("rw0_pc_en",    32'(hz.pc_en),       0);
        cyc();
        @(negedge clk);
        chk("rw1_pc_sel",   32'(hz.pc_sel),      0);
        chk("rw1_id_flush", 32'(hz.id_ex_flush), 0);
        cyc();
        @(negedge clk);
        chk("rw2_pc_sel",   32'(hz.pc_sel), 0);
        chk("rw2_pc_en",    32'(hz.pc_en),  0);
        cyc();
        @(negedge clk);
        chk("rw_rel_pc_sel",    32'(hz.pc_sel),      1);
        chk("rw_rel_if_flush",  32'(hz.if_id_flush), 1);
        chk("rw_rel_id_flush",  32'(hz.id_ex_flush), 1);
        chk("rw_rel_pc_en",     32'(hz.pc_en),       1);
        chk("rw_rel_flush_cnt", 32'(hz.flush_cnt),   0);
        cyc();
        idle();
        @(negedge clk);
        chk("rw_flush_cnt", 32'(hz.flush_cnt), 1);
        chk("rw_stall_cnt", 32'(hz.stall_cnt), 7);
        chk("rw_pc_sel",    32'(hz.pc_sel),    0);

        // Redirect and load-use together: redirect wins, no stall
        cyc();
        hz.ex_redirect = 1'b1;
        hz.ex_mem_read = 1'b1;
        hz.ex_rd       = 5'd5;
        hz.id_rs1      = 5'd5;
        hz.id_use_rs1  = 1'b1;
        @(negedge clk);
        chk("both_pc_en",    32'(hz.pc_en),       1);
        chk("both_pc_sel",   32'(hz.pc_sel),      1);
        chk("both_if_id_en", 32'(hz.if_id_en),    1);
        chk("both_if_flush", 32'(hz.if_id_flush), 1);
        chk("both_id_flush", 32'(hz.id_ex_flush), 1);
        cyc();
        idle();
        @(negedge clk);
        chk("both_flush_cnt", 32'(hz.flush_cnt), 2);
        chk("both_stall_cnt", 32'(hz.stall_cnt), 7);

        // Reset in the middle of WAIT
        cyc();
        hz.mem_periph = 1'b1;
        cyc();
        #1;
        chk("mw_wait_pc_en", 32'(hz.pc_en), 0);
        reset = 1'b0;
        #1;
        chk("mw_rst_pc_en",     32'(hz.pc_en),        0);
        chk("mw_rst_if_flush",  32'(hz.if_id_flush),  1);
        chk("mw_rst_ex_flush",  32'(hz.ex_mem_flush), 1);
        chk("mw_rst_mem_wb_en", 32'(hz.mem_wb_en),    0);
        chk("mw_rst_stall_cnt", 32'(hz.stall_cnt),    0);
        chk("mw_rst_flush_cnt", 32'(hz.flush_cnt),    0);
        idle();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("mw_init_id_flush", 32'(hz.id_ex_flush), 1);
        chk("mw_init_pc_en",    32'(hz.pc_en),       0);
        cyc();
        @(negedge clk);
        chk("mw_run_pc_en",     32'(hz.pc_en),     1);
        chk("mw_run_ex_mem_en", 32'(hz.ex_mem_en), 1);
        chk("mw_run_stall_cnt", 32'(hz.stall_cnt), 0);
        chk("mw_run_flush_cnt", 32'(hz.flush_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
